// File: rtl/sqrt_pkg.sv
// Shared types and width helpers for the square-root engine.
package sqrt_pkg;

    // Engine control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Root width: integer half of the radicand plus the fractional bits.
    function automatic int res_w(input int in_w, input int frac_w);
        return in_w / 2 + frac_w;
    endfunction

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_w(input int root_w);
        return (root_w > 1) ? $clog2(root_w) : 1;
    endfunction

endpackage

// File: rtl/sqrt_round_sat.sv
// Combinational rounding stage: optional round-to-nearest of the integer
// root with saturation at the top of the root range.
module sqrt_round_sat
    import sqrt_pkg::*;
#(
    parameter int RES_W = 16
) (
    input  logic [RES_W-1:0] root_i,
    input  logic [RES_W:0]   rem_i,
    input  logic             round_mode_i,
    output logic [RES_W-1:0] sqrt_o
);

    logic round_up;

    // Round up when the remainder exceeds the root (X is nearer (R+1)^2);
    // a root of all-ones cannot grow, so it saturates in place.
    always_comb begin
        round_up = round_mode_i && (rem_i > {1'b0, root_i});
        if (round_up && !(&root_i)) begin
            sqrt_o = root_i + RES_W'(1);
        end else begin
            sqrt_o = root_i;
        end
    end

endmodule

// File: rtl/sqrt_engine.sv
// Sequential restoring square-root engine. One root bit per cycle, MSB
// first, over X = in * 4^FRAC_W. The result is registered once the last
// bit is known, so out_valid rises RES_W+1 edges after the acceptance edge.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; valid never depends combinationally on ready, and the
// payload (sqrt/rem) is held stable while out_valid is high and out_ready
// is low.
module sqrt_engine
    import sqrt_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int FRAC_W = 8,
    localparam int RES_W = res_w(IN_W, FRAC_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    input  logic             round_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [RES_W-1:0] sqrt,
    output logic [RES_W:0]   rem,
    output logic             busy
);

    localparam int X_W   = 2 * RES_W;
    localparam int CNT_W = cnt_w(RES_W);
    localparam int ACC_W = RES_W + 3;

    state_e           state_q, state_d;
    logic [X_W-1:0]   x_q, x_d;
    logic [RES_W-1:0] root_q, root_d;
    logic [RES_W:0]   part_rem_q, part_rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             iter_done_q, iter_done_d;
    logic             round_q, round_d;
    logic [RES_W-1:0] sqrt_q, sqrt_d;
    logic [RES_W:0]   rem_q, rem_d;

    logic [ACC_W-1:0] rem_shift;
    logic [ACC_W-1:0] trial_sub;
    logic             trial_ok;
    logic [RES_W:0]   trial_diff;
    logic [RES_W-1:0] rounded;

    // One restoring step: bring down the next radicand bit pair and try
    // subtracting {root,01}. The true difference always fits RES_W+1 bits,
    // so the subtraction is done modulo 2^(RES_W+1) once the compare passes.
    always_comb begin
        rem_shift  = {part_rem_q, x_q[X_W-1 -: 2]};
        trial_sub  = {1'b0, root_q, 2'b01};
        trial_ok   = (rem_shift >= trial_sub);
        trial_diff = rem_shift[RES_W:0] - trial_sub[RES_W:0];
    end

    sqrt_round_sat #(
        .RES_W(RES_W)
    ) u_round_sat (
        .root_i      (root_q),
        .rem_i       (part_rem_q),
        .round_mode_i(round_q),
        .sqrt_o      (rounded)
    );

    // Next-state and handshake outputs. CALC spends RES_W cycles on the
    // iteration and one more registering the rounded result into sqrt/rem.
    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        root_d      = root_q;
        part_rem_d  = part_rem_q;
        cnt_d       = cnt_q;
        iter_done_d = iter_done_q;
        round_d     = round_q;
        sqrt_d      = sqrt_q;
        rem_d       = rem_q;
        in_ready    = 1'b0;
        out_valid   = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    x_d         = X_W'(in) << (2 * FRAC_W);
                    round_d     = round_mode;
                    root_d      = '0;
                    part_rem_d  = '0;
                    cnt_d       = CNT_W'(RES_W - 1);
                    iter_done_d = 1'b0;
                    state_d     = CALC;
                end
            end
            CALC: begin
                if (!iter_done_q) begin
                    x_d        = x_q << 2;
                    root_d     = (root_q << 1) | RES_W'(trial_ok);
                    part_rem_d = trial_ok ? trial_diff : rem_shift[RES_W:0];
                    if (cnt_q == '0) begin
                        iter_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end else begin
                    sqrt_d  = rounded;
                    rem_d   = part_rem_q;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            x_q         <= '0;
            root_q      <= '0;
            part_rem_q  <= '0;
            cnt_q       <= '0;
            iter_done_q <= 1'b0;
            round_q     <= 1'b0;
            sqrt_q      <= '0;
            rem_q       <= '0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            root_q      <= root_d;
            part_rem_q  <= part_rem_d;
            cnt_q       <= cnt_d;
            iter_done_q <= iter_done_d;
            round_q     <= round_d;
            sqrt_q      <= sqrt_d;
            rem_q       <= rem_d;
        end
    end

    assign sqrt = sqrt_q;
    assign rem  = rem_q;
    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_sqrt_engine.sv
// Self-checking bench for sqrt_engine: a default instance (IN_W=16,
// FRAC_W=8) and an integer-only instance (FRAC_W=0).
module tb_sqrt_engine;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance signals
    logic        in_valid, in_ready, rm, out_valid, out_ready, busy;
    logic [15:0] in_data;
    logic [15:0] sqrt_o;
    logic [16:0] rem_o;

    // FRAC_W=0 instance signals
    logic        b_in_valid, b_in_ready, b_rm, b_out_valid, b_out_ready, b_busy;
    logic [15:0] b_in;
    logic [7:0]  b_sqrt;
    logic [8:0]  b_rem;

    sqrt_engine dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in(in_data), .round_mode(rm), .out_valid(out_valid),
        .out_ready(out_ready), .sqrt(sqrt_o), .rem(rem_o), .busy(busy)
    );

    sqrt_engine #(.IN_W(16), .FRAC_W(0)) dut_int (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in(b_in), .round_mode(b_rm), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .sqrt(b_sqrt), .rem(b_rem), .busy(b_busy)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [32:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference: integer square root of X = a * 4^frac from plain arithmetic.
    function automatic void ref_model(input longint a, input bit mode, input int frac,
                                      input int in_w, output longint s, output longint r);
        longint x, q, maxr;
        maxr = (longint'(1) << (in_w / 2 + frac)) - 1;
        x = a << (2 * frac);
        q = longint'($sqrt(real'(x)));
        while (q * q > x) q--;
        while ((q + 1) * (q + 1) <= x) q++;
        r = x - q * q;
        s = (mode && r > q) ? ((q + 1 > maxr) ? maxr : q + 1) : q;
    endfunction

    function automatic logic [32:0] expect16(input logic [15:0] a, input bit mode);
        longint s, r;
        ref_model(longint'(a), mode, 8, 16, s, r);
        return {s[15:0], r[16:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [15:0] a, input bit mode);
        check("accept_in_ready", in_ready, 1);
        in_valid = 1'b1; in_data = a; rm = mode;
        step();
        in_valid = 1'b0;
        in_data = 16'($urandom);
        rm = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic run_b(input logic [15:0] a, input bit mode,
                         input logic [7:0] es, input logic [8:0] er);
        int lat;
        check("b_accept_in_ready", b_in_ready, 1);
        b_in_valid = 1'b1; b_in = a; b_rm = mode;
        step();
        b_in_valid = 1'b0;
        lat = 0;
        while (!b_out_valid && lat < 100) begin
            step();
            lat++;
        end
        check("b_latency", lat, 9);
        check("b_sqrt", b_sqrt, es);
        check("b_rem", b_rem, er);
        b_out_ready = 1'b1;
        step();
        b_out_ready = 1'b0;
        check("b_in_ready_after", b_in_ready, 1);
    endtask

    // Streaming phase: random (or back-to-back) traffic against exp_q.
    task automatic run_stream(input int n, input bit b2b);
        int n_acc, n_out, cyc, last_acc;
        logic [32:0] e;
        n_acc = 0; n_out = 0; cyc = 0; last_acc = -1;
        in_data = 16'($urandom); rm = 1'($urandom_range(0, 1));
        in_valid = 1'b1;
        out_ready = b2b ? 1'b1 : 1'($urandom_range(0, 1));
        while ((n_out < n || exp_q.size() != 0) && cyc < n * 80 + 200) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(expect16(in_data, rm));
                if (b2b && last_acc >= 0) check("b2b_period", cyc - last_acc, 19);
                last_acc = cyc;
                n_acc++;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_sqrt", sqrt_o, e[32:17]);
                    check("stream_rem", rem_o, e[16:0]);
                end
                n_out++;
            end
            step();
            cyc++;
            in_data = 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            in_valid = (n_acc < n) && (b2b || ($urandom_range(0, 3) != 0));
            out_ready = b2b || ($urandom_range(0, 1) == 1);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("stream_count", n_out, n);
        check("stream_queue_empty", exp_q.size(), 0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] a;
        bit          mode;
        logic [15:0] s;
        logic [16:0] r;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int lat;
        vecs[0] = '{16'd3,     1'b0, 16'd443,   17'd359};
        vecs[1] = '{16'd7,     1'b0, 16'd677,   17'd423};
        vecs[2] = '{16'd11,    1'b0, 16'd849,   17'd95};
        vecs[3] = '{16'd0,     1'b0, 16'd0,     17'd0};
        vecs[4] = '{16'd65535, 1'b1, 16'd65535, 17'd65535};
        vecs[5] = '{16'd10,    1'b0, 16'd809,   17'd879};
        vecs[6] = '{16'd10,    1'b1, 16'd810,   17'd879};
        vecs[7] = '{16'd1,     1'b1, 16'd256,   17'd0};

        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; rm = 1'b0; out_ready = 1'b0;
        b_in_valid = 1'b0; b_in = '0; b_rm = 1'b0; b_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sqrt", sqrt_o, 0);
        check("rst_rem", rem_o, 0);
        check("rst_b_in_ready", b_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        rst = 1'b0;

        // Table-driven vectors; the first is offered on the very first
        // edge after reset release.
        foreach (vecs[i]) begin
            accept(vecs[i].a, vecs[i].mode);
            check("calc_busy", busy, 1);
            check("calc_in_ready", in_ready, 0);
            wait_done(lat);
            check("latency", lat, 17);
            check("vec_sqrt", sqrt_o, vecs[i].s);
            check("vec_rem", rem_o, vecs[i].r);
            release_result();
            check("in_ready_after_release", in_ready, 1);
            check("out_valid_after_release", out_valid, 0);
        end

        // Integer-only instance: saturation and plain round-up
        run_b(16'd65535, 1'b1, 8'd255, 9'd510);
        run_b(16'd8, 1'b1, 8'd3, 9'd4);
        run_b(16'd8, 1'b0, 8'd2, 9'd4);

        // Stalled consumer: result held, new offers ignored
        accept(16'd7, 1'b0);
        wait_done(lat);
        check("hold_latency", lat, 17);
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'b1;
            in_data = 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            step();
            check("hold_sqrt", sqrt_o, 677);
            check("hold_rem", rem_o, 423);
            check("hold_out_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("hold_in_ready_after", in_ready, 1);
        check("handshake_no_accept", busy, 0);
        in_valid = 1'b0;

        // Reset abort mid-calculation
        accept(16'd11, 1'b0);
        repeat (5) step();
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_sqrt", sqrt_o, 0);
        check("abort_rem", rem_o, 0);
        check("abort_in_ready", in_ready, 1);
        step();
        rst = 1'b0;
        accept(16'd7, 1'b0);
        wait_done(lat);
        check("abort_new_latency", lat, 17);
        check("abort_new_sqrt", sqrt_o, 677);
        check("abort_new_rem", rem_o, 423);
        release_result();

        // Back-to-back, then randomized traffic with consumer stalls
        run_stream(10, 1'b1);
        run_stream(25, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_checks);
        $fatal(1);
    end

endmodule
